// File: rtl/ctc_pkg.sv
`default_nettype none
// ============================================================================
// ctc_pkg : shared types and default geometry for the calculator timing core
// Rev 1.0
// ============================================================================
package ctc_pkg;

  localparam int CTC_NDIG  = 14;
  localparam int CTC_DBITS = 4;
  localparam int CTC_SYNC  = 10;
  localparam int CTC_KROWS = 8;
  localparam int CTC_KCOLS = 5;
  localparam int CTC_DEB   = 2;

  localparam int CTC_W  = CTC_NDIG * CTC_DBITS;
  localparam int CTC_PW = $clog2(CTC_NDIG);
  localparam int CTC_BW = $clog2(CTC_W);
  localparam int CTC_RW = $clog2(CTC_KROWS);
  localparam int CTC_CW = $clog2(CTC_KCOLS);

  typedef enum logic [2:0] {
    WS_P   = 3'd0,
    WS_WP  = 3'd1,
    WS_X   = 3'd2,
    WS_W   = 3'd3,
    WS_M   = 3'd4,
    WS_S   = 3'd5,
    WS_MS  = 3'd6,
    WS_OFF = 3'd7
  } ws_mode_e;

  typedef enum logic [1:0] {
    PTR_NONE = 2'd0,
    PTR_LOAD = 2'd1,
    PTR_INC  = 2'd2,
    PTR_DEC  = 2'd3
  } ptr_op_e;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_CONFIRM = 2'd1,
    DB_VALID   = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_e;

endpackage
`default_nettype wire

// File: rtl/ctc_key_debounce.sv
`default_nettype none
// ============================================================================
// ctc_key_debounce : per-frame first-hit capture and multi-frame key debounce
// Rev 1.0
// ============================================================================
module ctc_key_debounce
  import ctc_pkg::*;
#(
  parameter int CODE_W = CTC_RW + CTC_CW,
  parameter int DEB    = CTC_DEB
) (
  input  logic              cph2,
  input  logic              nrst,
  input  logic              sample_i,
  input  logic              frame_end_i,
  input  logic              hit_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              key_ack_i,
  output logic              key_valid_o,
  output logic [CODE_W-1:0] key_code_o
);

  localparam int NW = $clog2(DEB + 1);

  db_state_e         state_q, state_d;
  logic              found_q, found_d;
  logic [CODE_W-1:0] fcode_q, fcode_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [NW-1:0]     n_q, n_d;
  logic              w_frame_hit;
  logic [CODE_W-1:0] w_frame_code;

  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      state_q <= DB_IDLE;
      found_q <= 1'b0;
      fcode_q <= '0;
      cand_q  <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      found_q <= found_d;
      fcode_q <= fcode_d;
      cand_q  <= cand_d;
      n_q     <= n_d;
    end
  end

  // The last row's sample arrives together with frame_end, so it is merged here
  always_comb begin
    w_frame_hit  = found_q | hit_i;
    w_frame_code = found_q ? fcode_q : code_i;
    found_d      = found_q;
    fcode_d      = fcode_q;
    if (frame_end_i) begin
      found_d = 1'b0;
    end else if (sample_i && hit_i && !found_q) begin
      found_d = 1'b1;
      fcode_d = code_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    n_d     = n_q;
    case (state_q)
      DB_IDLE: begin
        if (frame_end_i && w_frame_hit) begin
          cand_d  = w_frame_code;
          n_d     = NW'(1);
          state_d = (DEB == 1) ? DB_VALID : DB_CONFIRM;
        end
      end
      DB_CONFIRM: begin
        if (frame_end_i) begin
          if (!w_frame_hit) begin
            state_d = DB_IDLE;
          end else if (w_frame_code == cand_q) begin
            n_d = n_q + NW'(1);
            if (n_q + NW'(1) == NW'(DEB)) state_d = DB_VALID;
          end else begin
            cand_d = w_frame_code;
            n_d    = NW'(1);
          end
        end
      end
      DB_VALID: begin
        if (key_ack_i) state_d = DB_RELEASE;
      end
      DB_RELEASE: begin
        if (frame_end_i && !w_frame_hit) state_d = DB_IDLE;
      end
      default: state_d = DB_IDLE;
    endcase
  end

  always_comb begin
    key_valid_o = (state_q == DB_VALID);
    key_code_o  = (state_q == DB_VALID) ? cand_q : '0;
  end

endmodule
`default_nettype wire

// File: rtl/ctc_scan_timer.sv
`default_nettype none
// ============================================================================
// ctc_scan_timer : word/digit timebase, WS field strobe, pointer and key scan
// Rev 1.0
// ============================================================================
module ctc_scan_timer
  import ctc_pkg::*;
#(
  parameter  int NDIG  = CTC_NDIG,
  parameter  int DBITS = CTC_DBITS,
  parameter  int SYNC  = CTC_SYNC,
  parameter  int KROWS = CTC_KROWS,
  parameter  int KCOLS = CTC_KCOLS,
  parameter  int DEB   = CTC_DEB,
  localparam int W     = NDIG * DBITS,
  localparam int PW    = $clog2(NDIG),
  localparam int BW    = $clog2(W),
  localparam int RW    = $clog2(KROWS),
  localparam int CW    = $clog2(KCOLS),
  localparam int KW    = RW + CW
) (
  input  logic          cph2,
  input  logic          nrst,
  input  logic [2:0]    ws_mode,
  input  logic          ws_load,
  input  logic [1:0]    ptr_op,
  input  logic [PW-1:0] ptr_val,
  input  logic [KCOLS-1:0] kc,
  input  logic          key_ack,
  output logic [BW-1:0] bit_cnt,
  output logic [PW-1:0] digit,
  output logic          sync,
  output logic          t_last,
  output logic          ws,
  output logic [PW-1:0] ptr,
  output logic [KROWS-1:0] kr,
  output logic          key_valid,
  output logic [KW-1:0] key_code
);

  logic [BW-1:0] bit_cnt_q;
  logic [PW-1:0] ptr_q, ptr_d;
  ws_mode_e      ws_mode_q;
  logic [RW-1:0] row_q;
  logic [PW-1:0] w_digit;
  logic          w_t_last;
  logic          w_frame_end;
  logic          w_hit;
  logic [CW-1:0] w_col;

  assign w_t_last    = (bit_cnt_q == BW'(W - 1));
  assign w_digit     = PW'(bit_cnt_q / BW'(DBITS));
  assign w_frame_end = w_t_last && (row_q == RW'(KROWS - 1));
  assign w_hit       = |kc;

  assign bit_cnt = bit_cnt_q;
  assign digit   = w_digit;
  assign t_last  = w_t_last;
  assign ptr     = ptr_q;
  assign sync    = (bit_cnt_q >= BW'(W - 1 - SYNC)) && (bit_cnt_q <= BW'(W - 2));

  always_comb begin
    ptr_d = ptr_q;
    case (ptr_op_e'(ptr_op))
      PTR_LOAD: ptr_d = (int'(ptr_val) >= NDIG) ? PW'(NDIG - 1) : ptr_val;
      PTR_INC:  ptr_d = (ptr_q == PW'(NDIG - 1)) ? '0 : ptr_q + PW'(1);
      PTR_DEC:  ptr_d = (ptr_q == '0) ? PW'(NDIG - 1) : ptr_q - PW'(1);
      default:  ptr_d = ptr_q;
    endcase
  end

  // Pointer, mode and row all change only at word end so a word sees stable state
  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      bit_cnt_q <= '0;
      ptr_q     <= '0;
      ws_mode_q <= WS_OFF;
      row_q     <= '0;
    end else begin
      bit_cnt_q <= w_t_last ? '0 : bit_cnt_q + BW'(1);
      if (w_t_last) begin
        ptr_q <= ptr_d;
        if (ws_load) ws_mode_q <= ws_mode_e'(ws_mode);
        row_q <= (row_q == RW'(KROWS - 1)) ? '0 : row_q + RW'(1);
      end
    end
  end

  always_comb begin
    ws = 1'b0;
    case (ws_mode_q)
      WS_P:    ws = (w_digit == ptr_q);
      WS_WP:   ws = (w_digit <= ptr_q);
      WS_X:    ws = (w_digit <= PW'(2));
      WS_W:    ws = 1'b1;
      WS_M:    ws = (w_digit >= PW'(3)) && (w_digit <= PW'(NDIG - 2));
      WS_S:    ws = (w_digit == PW'(NDIG - 1));
      WS_MS:   ws = (w_digit >= PW'(3));
      default: ws = 1'b0;
    endcase
  end

  // Lowest asserted column wins within the driven row
  always_comb begin
    kr        = '0;
    kr[row_q] = 1'b1;
    w_col     = '0;
    for (int i = KCOLS - 1; i >= 0; i--) begin
      if (kc[i]) w_col = CW'(i);
    end
  end

  ctc_key_debounce #(
    .CODE_W (KW),
    .DEB    (DEB)
  ) u_debounce (
    .cph2        (cph2),
    .nrst        (nrst),
    .sample_i    (w_t_last),
    .frame_end_i (w_frame_end),
    .hit_i       (w_hit),
    .code_i      ({row_q, w_col}),
    .key_ack_i   (key_ack),
    .key_valid_o (key_valid),
    .key_code_o  (key_code)
  );

endmodule
`default_nettype wire

// File: doc/ctc_scan_timer.md
# ctc_scan_timer

Parametrised timing, word-select and keyboard-scan generator for the calculator core. It is the next generation of the control-and-timing block. It generates the word/digit/bit timebase, the sync window and the WS field strobe from a pointer register. It also scans a KROWS×KCOLS key matrix with multi-frame debounce and a valid/ack key handshake toward the microsequencer.

## Interface
Parameters:
- NDIG, 14, digits per word
- DBITS, 4, bit-times per digit; word length W = NDIG*DBITS
- SYNC, 10, sync window length in bit-times
- KROWS, 8, key matrix rows (kr drive)
- KCOLS, 5, key matrix columns (kc sense)
- DEB, 2, consecutive identical frames required to accept a key (≥1)

Ports:
- cph2  in  1  system clock, all logic on rising edge
- nrst  in  1  asynchronous active-low reset
- ws_mode  in  3  field select, latched by ws_load
- ws_load  in  1  latch ws_mode at word end
- ptr_op  in  2  00 none, 01 load, 10 inc, 11 dec
- ptr_val  in  PW=clog2(NDIG)  load value
- kc  in  KCOLS  column sense, active high
- key_ack  in  1  consumer accepted key_code
- bit_cnt  out  clog2(W)  bit-time index 0..W-1
- digit  out  PW  current digit (bit_cnt/DBITS)
- sync  out  1  high for bit-times W-1-SYNC .. W-2
- t_last  out  1  high at bit-time W-1
- ws  out  1  word-select strobe
- ptr  out  PW  pointer register
- kr  out  KROWS  one-hot row drive
- key_valid  out  1  debounced key pending
- key_code  out  clog2(KROWS)+clog2(KCOLS)  {row, col}

## Operation
- Counter: bit_cnt increments each cycle and wraps W-1→0. digit and t_last are decoded from it.
- Pointer update at t_last only:
  - load: ptr_val ≥ NDIG clamps to NDIG-1.
  - inc: wraps NDIG-1→0.
  - dec: wraps 0→NDIG-1.
- ws_mode is latched at t_last when ws_load=1. It takes effect from bit-time 0 of the next word. When ws_load and ptr_op coincide, the new mode uses the updated ptr.
- ws modes, asserted for all DBITS bit-times of each selected digit:
  - 000 P: digit==ptr
  - 001 WP: digit≤ptr
  - 010 X: digits 0–2
  - 011 W: all digits
  - 100 M: digits 3..NDIG-2
  - 101 S: digit NDIG-1
  - 110 MS: digits 3..NDIG-1
  - 111 off: ws=0
- Scan: one row is driven per word. The row index advances at t_last and wraps KROWS-1→0. kc is sampled at t_last, giving a full word of settling.
- Frame = KROWS words. Frame hit = first row with any kc bit high; within that row, the lowest column index wins.
- Debounce FSM, evaluated at the frame end (t_last of row KROWS-1):
  - IDLE: on hit, cand=code, n=1, go to CONFIRM. If DEB=1, go straight to VALID.
  - CONFIRM: same code → n++. When n==DEB, go to VALID. A different code reloads cand with n=1. No hit → IDLE.
  - VALID: key_valid=1 and key_code=cand, both held stable until key_ack is sampled high, then go to RELEASE. key_ack outside VALID is ignored.
  - RELEASE: a frame with no hit → IDLE. Held keys never re-trigger.

## Timing
- Reset values: bit_cnt=0, digit=0, ptr=0, ws_mode=111 (ws=0), kr=row 0 one-hot, key_valid=0, key_code=0, FSM=IDLE, sync=0, t_last=0.
- Reset mid-word or mid-debounce aborts immediately, and all state returns to reset values. The first cycle after release is bit-time 0.
- ws, sync and t_last are combinational decodes of registered state, so they have zero latency relative to bit_cnt.
- key_valid rises in the cycle after the accepting frame end. The minimum key latency from a stable press is DEB*KROWS*W cycles plus alignment.
- When key_ack and a frame end coincide in VALID, the ack wins and the next state is RELEASE.

## Structure
- Shared package ctc_pkg holds:
  - ws_mode_e (P, WP, X, W, M, S, MS, OFF)
  - ptr_op_e
  - debounce state enum
  - localparams W, PW, clog2 widths
- Sub-module ctc_key_debounce holds the frame-hit capture and debounce FSM. It takes frame_end, hit and code as inputs and produces key_valid and key_code. Timebase, pointer and WS logic stay in the top module.

## Test plan
- Reset release, defaults: bit_cnt 0..55 wraps; sync high exactly at 45..54; t_last at 55; ws=0 all word; kr=0x01.
- ptr load 5, mode P → ws high bit-times 20–23. Mode WP → ws high 0–23. dec from 0 → ptr=13.
- Load ptr_val=15 → ptr=13. ws_load(WP) simultaneous with inc from 3 → next word ws high 0–19.
- Key row 2 col 3 held 3 frames, DEB=2 → key_valid after frame 2, key_code={2,3}. No repeat while held. Release one frame, press again → new valid after ack.
- Bounce: code changes between frames (row1col0 then row2col0) → no valid until 2 identical frames. Two keys in the same row (cols 1 and 4) → col 1 reported.
- nrst asserted in CONFIRM and mid-word → all outputs return to reset values at once. A full DEB re-confirmation is required afterwards.
